// File: rtl/srl_seq.sv
// Sequential right shift / arithmetic shift / rotate unit for the 16-bit datapath.
// Moves at most two bit positions per clock; start/done handshake, result held on out.
module srl_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   work_step;
  logic [CNT_W-1:0]    rem;
  logic [CNT_W-1:0]    rem_nxt;
  logic [1:0]          mode_q;
  logic                two_step;

  // One shift step of one or two positions; mode 11 falls through to SRL.
  function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        m,
                                                   input logic              two);
    logic signed [DATA_W-1:0] ws;
    ws = signed'(w);
    case (m)
      MODE_SRA: shift_step = two ? DATA_W'(ws >>> 2) : DATA_W'(ws >>> 1);
      MODE_ROR: shift_step = two ? {w[1:0], w[DATA_W-1:2]} : {w[0], w[DATA_W-1:1]};
      default:  shift_step = two ? (w >> 2) : (w >> 1);
    endcase
  endfunction

  always_comb begin
    two_step  = (rem >= CNT_W'(2));
    rem_nxt   = two_step ? rem - CNT_W'(2) : rem - CNT_W'(1);
    work_step = shift_step(work, mode_q, two_step);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cnt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, stepping and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      mode_q <= '0;
      out    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= in;
            rem    <= cnt;
            mode_q <= mode;
            if (cnt == '0) out <= in;
          end
        end
        SHIFT: begin
          work <= work_step;
          rem  <= rem_nxt;
          if (rem_nxt == '0) out <= work_step;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/srl_seq.md
# srl_seq

Sequential right-shift/rotate unit for the 16-bit datapath; it is the right-direction counterpart of the combinational left-shift stages. It accepts one operand per request through a start/done handshake. It shifts right logically, right arithmetically, or rotates right by 0-15 positions, stepping at most 2 bit positions per clock. It sits beside the ALU and is used by multi-cycle shift instructions, freeing the single-cycle path from a full right barrel shifter.

## Interface
Parameters: none (data width fixed at 16, count width fixed at 4).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset; sampled on clk rising edge
- start  input  1  request; sampled only in IDLE
- in  input  16  operand, captured when start accepted
- cnt  input  4  shift amount 0-15, captured when start accepted
- mode  input  2  00 = SRL (zero fill), 01 = SRA (sign fill from bit 15), 10 = ROR (bit 0 wraps to bit 15), 11 = reserved, executes as SRL
- busy  output  1  high whenever state is not IDLE
- done  output  1  single-cycle pulse, result valid on out
- out  output  16  result register; holds last result until next done

## Operation
- Internal registers: state (IDLE, SHIFT, DONE), work[15:0], rem[3:0], mode_q[1:0], out[15:0].
- IDLE, start=1: work<=in, rem<=cnt, mode_q<=mode. If cnt==0 -> DONE; else -> SHIFT. IDLE, start=0: stay.
- SHIFT, each cycle:
  - If rem>=2: shift work right by 2, rem<=rem-2.
  - Else: shift work right by 1, rem<=rem-1.
  - If the new rem==0: -> DONE; else stay in SHIFT.
- Fill rules per step:
  - SRL inserts 0s at the top.
  - SRA inserts copies of the current work[15]. The sign is preserved because work[15] never changes under SRA.
  - ROR moves the bits shifted out of bit 0 (and bit 1, for a 2-bit step) into the top in rotation order. For a 2-bit step: new[15]=work[1], new[14]=work[0].
- Entry into DONE: out<=final work value (for cnt==0, out<=in unchanged).
- DONE: done=1 for exactly this cycle, then -> IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing; a dropped request must be reissued after busy falls.
- Input changes after acceptance have no effect (in/cnt/mode are captured).
- Reset (rst_n=0 at a clock edge), in any state:
  - state<=IDLE, out<=0, work<=0, rem<=0.
  - No done pulse is produced for an aborted operation.
  - Reset has priority over start.

## Timing
- Reset values: busy=0, done=0, out=16'h0000.
- With start sampled high in IDLE during cycle k and capture count N:
  - SHIFT occupies cycles k+1 .. k+ceil(N/2).
  - done=1 and out valid in cycle k+1+ceil(N/2).
  - busy=1 from cycle k+1 through the done cycle inclusive.
- Latency examples: N=0 -> done at k+1; N=1 or 2 -> k+2; N=15 -> k+9.
- Earliest next acceptance: the cycle after done (IDLE), i.e. back-to-back throughput is one request per ceil(N/2)+2 cycles.
- out changes only on DONE entry or reset; it is stable during SHIFT.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- SRL: in=16'h8001, cnt=4, mode=00, start in cycle k -> done only in cycle k+3, out=16'h0800, busy high in k+1..k+3.
- SRA: in=16'h8001, cnt=5 -> out=16'hFC00 at k+4. Also in=16'h8000, cnt=15 -> out=16'hFFFF at k+9.
- ROR: in=16'h8001, cnt=1 -> out=16'hC000 at k+2. Also in=16'h1234, cnt=8 -> out=16'h3412 at k+5.
- cnt=0 with any mode, in=16'hA5A5 -> done at k+1, out=16'hA5A5. Also mode=11, in=16'h8000, cnt=3 -> out=16'h1000 (SRL behaviour).
- Start in cycle k+1 while busy (in=16'hFFFF, cnt=2, same mode) -> ignored: exactly one done pulse, and the result reflects the first request only.
- Reset: rst_n low in a SHIFT cycle -> next cycle busy=0, done=0, out=16'h0000, and no done pulse follows. A new start after reset completes normally.
